// File: rtl/ctrl_accum_n.sv
// ctrl_accum_n -- control FSM for the byte-accumulate-to-RAM datapath.
//
// Pops bytes from an upstream FIFO and groups them into words of
// BYTES_PER_WORD bytes. It drives the accumulator load/add strobes and
// issues one RAM write per completed word at an auto-incrementing address.
// When the RAM is exhausted it either wraps the address to 0 (WRAP=1) or
// stops reading and raises a sticky ram_full flag (WRAP=0).
//
// Parameters:
//   BYTES_PER_WORD  bytes summed per RAM word (2..16)
//   RAM_DEPTH       number of RAM words (2..65536)
//   ADDR_W          RAM address width, clog2(RAM_DEPTH)
//   WRAP            1 = wrap address to 0, 0 = stop and flag full
//
// Ports:
//   clk             clock
//   reset_n         asynchronous active-low reset
//   fifo_empty      upstream FIFO empty flag
//   enable          1 = reads allowed, 0 = pause and hold state
//   clear           synchronous clear (aborts partial word, zeroes address)
//   read            FIFO pop strobe (combinational)
//   acc_en          accumulator update strobe; FIFO data valid this cycle
//   zero_sel        with acc_en: load the byte instead of adding it
//   write_ram       one-cycle RAM write strobe
//   ram_addr        RAM write address, valid while write_ram=1
//   byte_idx        index of the next byte to be read
//   ram_full        sticky RAM-exhausted flag (WRAP=0 only)
//   words_written   saturating count of RAM writes since reset/clear
//                   (present only when CTRL_ACCUM_N_WORD_CNT_EN is defined)
//
// Optional feature macro: CTRL_ACCUM_N_WORD_CNT_EN

module ctrl_accum_n #(
    parameter int BYTES_PER_WORD = 4,
    parameter int RAM_DEPTH      = 256,
    parameter int ADDR_W         = 8,
    parameter int WRAP           = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              fifo_empty,
    input  logic              enable,
    input  logic              clear,
    output logic              read,
    output logic              acc_en,
    output logic              zero_sel,
    output logic              write_ram,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [3:0]        byte_idx,
    output logic              ram_full
`ifdef CTRL_ACCUM_N_WORD_CNT_EN
    ,
    output logic [ADDR_W:0]   words_written
`endif
);

    localparam logic [3:0]        LAST_IDX  = 4'(BYTES_PER_WORD - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_DEPTH - 1);

    logic [3:0]        byte_cnt;
    logic [ADDR_W-1:0] rd_word;   // word slot the bytes now being read will fill
    logic              rd_stop;   // final word fully read; no further pops
    logic              last_s1;   // stage-1 byte is the last of its word
    logic              last_read;

    // rd_stop closes the gap between reading the final word's last byte and
    // ram_full rising three cycles later, so no byte is popped and dropped.
    assign read      = ~fifo_empty & enable & ~ram_full & ~rd_stop & ~clear;
    assign last_read = read & (byte_cnt == LAST_IDX);
    assign byte_idx  = byte_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            byte_cnt  <= '0;
            rd_word   <= '0;
            rd_stop   <= 1'b0;
            acc_en    <= 1'b0;
            zero_sel  <= 1'b0;
            last_s1   <= 1'b0;
            write_ram <= 1'b0;
            ram_addr  <= '0;
            ram_full  <= 1'b0;
        end else if (clear) begin
            byte_cnt  <= '0;
            rd_word   <= '0;
            rd_stop   <= 1'b0;
            acc_en    <= 1'b0;
            zero_sel  <= 1'b0;
            last_s1   <= 1'b0;
            write_ram <= 1'b0;
            ram_addr  <= '0;
            ram_full  <= 1'b0;
        end else begin
            // Pipeline: read -> acc_en/zero_sel -> write_ram. Stages always
            // advance, so enable/ram_full only stop new reads.
            acc_en    <= read;
            zero_sel  <= read & (byte_cnt == '0);
            last_s1   <= last_read;
            write_ram <= acc_en & last_s1;

            if (read) begin
                byte_cnt <= (byte_cnt == LAST_IDX) ? '0 : byte_cnt + 4'd1;
            end

            if (last_read) begin
                if (rd_word == LAST_ADDR) begin
                    rd_word <= '0;
                    if (WRAP == 0) begin
                        rd_stop <= 1'b1;
                    end
                end else begin
                    rd_word <= rd_word + ADDR_W'(1);
                end
            end

            if (write_ram) begin
                if (ram_addr == LAST_ADDR) begin
                    if (WRAP != 0) begin
                        ram_addr <= '0;
                    end else begin
                        ram_full <= 1'b1;
                    end
                end else begin
                    ram_addr <= ram_addr + ADDR_W'(1);
                end
            end
        end
    end

`ifdef CTRL_ACCUM_N_WORD_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            words_written <= '0;
        end else if (clear) begin
            words_written <= '0;
        end else if (write_ram && (words_written != '1)) begin
            words_written <= words_written + (ADDR_W + 1)'(1);
        end
    end
`endif

endmodule

// File: tb/tb_ctrl_accum_n.sv
// Self-checking bench for ctrl_accum_n: three instances (default config,
// 3-byte words with a 4-word stopping RAM, 4-byte words with a 4-word
// wrapping RAM) share one stimulus stream and are compared every cycle
// against a behavioural model built from word/byte counts.

module tb_ctrl_accum_n;

    localparam int BPW   [3] = '{4, 3, 4};
    localparam int DEPTH [3] = '{256, 4, 4};
    localparam int WRAPF [3] = '{0, 0, 1};
    localparam int AW    [3] = '{8, 2, 2};

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic fifo_empty = 1'b1;
    logic enable = 1'b1;
    logic clear = 1'b0;

    logic        a_rd [3];
    logic        a_ae [3];
    logic        a_zs [3];
    logic        a_wr [3];
    logic        a_full [3];
    logic [3:0]  a_idx [3];
    logic [15:0] a_addr [3];
    logic [7:0]  addr0;
    logic [1:0]  addr1, addr2;

    assign a_addr[0] = {8'd0, addr0};
    assign a_addr[1] = {14'd0, addr1};
    assign a_addr[2] = {14'd0, addr2};

`ifdef CTRL_ACCUM_N_WORD_CNT_EN
    logic [8:0]  ww0;
    logic [2:0]  ww1, ww2;
    logic [15:0] a_ww [3];
    assign a_ww[0] = {7'd0, ww0};
    assign a_ww[1] = {13'd0, ww1};
    assign a_ww[2] = {13'd0, ww2};
`endif

    ctrl_accum_n u0 (
        .clk(clk), .reset_n(reset_n), .fifo_empty(fifo_empty),
        .enable(enable), .clear(clear), .read(a_rd[0]), .acc_en(a_ae[0]),
        .zero_sel(a_zs[0]), .write_ram(a_wr[0]), .ram_addr(addr0),
        .byte_idx(a_idx[0]), .ram_full(a_full[0])
`ifdef CTRL_ACCUM_N_WORD_CNT_EN
        , .words_written(ww0)
`endif
    );

    ctrl_accum_n #(.BYTES_PER_WORD(3), .RAM_DEPTH(4), .ADDR_W(2), .WRAP(0)) u1 (
        .clk(clk), .reset_n(reset_n), .fifo_empty(fifo_empty),
        .enable(enable), .clear(clear), .read(a_rd[1]), .acc_en(a_ae[1]),
        .zero_sel(a_zs[1]), .write_ram(a_wr[1]), .ram_addr(addr1),
        .byte_idx(a_idx[1]), .ram_full(a_full[1])
`ifdef CTRL_ACCUM_N_WORD_CNT_EN
        , .words_written(ww1)
`endif
    );

    ctrl_accum_n #(.BYTES_PER_WORD(4), .RAM_DEPTH(4), .ADDR_W(2), .WRAP(1)) u2 (
        .clk(clk), .reset_n(reset_n), .fifo_empty(fifo_empty),
        .enable(enable), .clear(clear), .read(a_rd[2]), .acc_en(a_ae[2]),
        .zero_sel(a_zs[2]), .write_ram(a_wr[2]), .ram_addr(addr2),
        .byte_idx(a_idx[2]), .ram_full(a_full[2])
`ifdef CTRL_ACCUM_N_WORD_CNT_EN
        , .words_written(ww2)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int inst, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            if (n_bad <= 60)
                $display("FAIL %s u%0d t=%0t actual=%0d required=%0d", nm, inst, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // cnt: bytes of the current word already read; wread: words whose last
    // byte was read since reset/clear; wr: RAM writes since reset/clear.
    // r1/i1 and r2/i2: whether a byte was read one/two cycles ago and its
    // position in the word; c1: clear was high last cycle.
    int cnt [3];
    int wread [3];
    int wr [3];
    int i1 [3];
    int i2 [3];
    bit r1 [3];
    bit r2 [3];
    bit c1;

    function automatic bit m_read(int i);
        return !fifo_empty && enable && !clear && !(WRAPF[i] == 0 && wread[i] >= DEPTH[i]);
    endfunction

    function automatic bit m_wr(int i);
        return r2[i] && (i2[i] == BPW[i] - 1) && !c1;
    endfunction

    function automatic int m_addr(int i);
        if (WRAPF[i] != 0) return wr[i] % DEPTH[i];
        return (wr[i] >= DEPTH[i]) ? DEPTH[i] - 1 : wr[i];
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) begin
            cnt[i] = 0; wread[i] = 0; wr[i] = 0;
            i1[i] = 0; i2[i] = 0; r1[i] = 0; r2[i] = 0;
        end
        c1 = 0;
    endfunction

    always @(negedge reset_n) model_reset();

    always @(posedge clk) begin
        if (!reset_n) begin
            model_reset();
        end else begin
            for (int i = 0; i < 3; i++) begin
                bit rd;
                bit w;
                rd = m_read(i);
                w  = m_wr(i);
                if (w) wr[i]++;
                r2[i] = r1[i]; i2[i] = i1[i];
                r1[i] = rd;    i1[i] = cnt[i];
                if (rd) begin
                    if (cnt[i] == BPW[i] - 1) begin
                        cnt[i] = 0;
                        wread[i]++;
                    end else begin
                        cnt[i]++;
                    end
                end
                if (clear) begin
                    cnt[i] = 0; wread[i] = 0; wr[i] = 0;
                end
            end
            c1 = clear;
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        if ($time > 0) begin
            for (int i = 0; i < 3; i++) begin
                chk("read",      i, a_rd[i],   m_read(i));
                chk("acc_en",    i, a_ae[i],   r1[i]);
                chk("zero_sel",  i, a_zs[i],   r1[i] && i1[i] == 0);
                chk("write_ram", i, a_wr[i],   m_wr(i));
                chk("byte_idx",  i, a_idx[i],  cnt[i]);
                chk("ram_addr",  i, a_addr[i], m_addr(i));
                chk("ram_full",  i, a_full[i], (WRAPF[i] == 0) && (wr[i] >= DEPTH[i]));
`ifdef CTRL_ACCUM_N_WORD_CNT_EN
                chk("words_written", i, a_ww[i],
                    (wr[i] > (1 << (AW[i] + 1)) - 1) ? (1 << (AW[i] + 1)) - 1 : wr[i]);
`endif
            end
        end
    end

    // ---------------- stimulus and literal expectations ----------------
    int wn [3];
    int wcyc [3][16];
    int waddr [3][16];
    int zs_c [16];
    int zn;
    bit u1_full13, u1_full14, u1_rd12, u1_rd29, u2_full29;
    int nw;

    initial begin
        #2 reset_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_acc_en",    i, a_ae[i],   0);
            chk("rst_zero_sel",  i, a_zs[i],   0);
            chk("rst_write_ram", i, a_wr[i],   0);
            chk("rst_byte_idx",  i, a_idx[i],  0);
            chk("rst_ram_addr",  i, a_addr[i], 0);
            chk("rst_ram_full",  i, a_full[i], 0);
        end
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // Continuous stream of 30 bytes.
        @(posedge clk);
        #1 fifo_empty = 1'b0;
        zn = 0;
        for (int i = 0; i < 3; i++) wn[i] = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (a_wr[i] && wn[i] < 16) begin
                    wcyc[i][wn[i]]  = k;
                    waddr[i][wn[i]] = int'(a_addr[i]);
                    wn[i]++;
                end
            end
            if (a_zs[0] && a_ae[0] && zn < 16) begin
                zs_c[zn] = k;
                zn++;
            end
            if (k == 12) u1_rd12   = a_rd[1];
            if (k == 13) u1_full13 = a_full[1];
            if (k == 14) u1_full14 = a_full[1];
            if (k == 29) begin
                u1_rd29   = a_rd[1];
                u2_full29 = a_full[2];
            end
        end
        @(posedge clk);
        #1 fifo_empty = 1'b1;

        chk("lit_u0_nwrites", 0, wn[0], 7);
        chk("lit_u0_w0_cyc",  0, wcyc[0][0], 5);
        chk("lit_u0_w0_addr", 0, waddr[0][0], 0);
        chk("lit_u0_w1_cyc",  0, wcyc[0][1], 9);
        chk("lit_u0_w1_addr", 0, waddr[0][1], 1);
        chk("lit_u0_zs0_cyc", 0, zs_c[0], 1);
        chk("lit_u0_zs1_cyc", 0, zs_c[1], 5);
        chk("lit_u1_nwrites", 1, wn[1], 4);
        chk("lit_u1_w3_cyc",  1, wcyc[1][3], 13);
        chk("lit_u1_w3_addr", 1, waddr[1][3], 3);
        chk("lit_u1_full13",  1, u1_full13, 0);
        chk("lit_u1_full14",  1, u1_full14, 1);
        chk("lit_u1_read12",  1, u1_rd12, 0);
        chk("lit_u1_read29",  1, u1_rd29, 0);
        chk("lit_u2_nwrites", 2, wn[2], 7);
        chk("lit_u2_w3_addr", 2, waddr[2][3], 3);
        chk("lit_u2_w4_addr", 2, waddr[2][4], 0);
        chk("lit_u2_full",    2, u2_full29, 0);

        // clear in the cycle after the 4th read of a word.
        repeat (4) @(posedge clk);
        #1 clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        fifo_empty = 1'b0;
        repeat (4) @(posedge clk);
        #1 clear = 1'b1;
        fifo_empty = 1'b1;
        nw = 0;
        @(negedge clk);
        if (a_wr[0]) nw++;
        @(posedge clk);
        #1 clear = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (a_wr[0]) nw++;
            if (k == 0) begin
                chk("lit_clr_byte_idx", 0, a_idx[0], 0);
                chk("lit_clr_ram_addr", 0, a_addr[0], 0);
                chk("lit_clr_u1_full",  1, a_full[1], 0);
            end
        end
        chk("lit_clr_nwrites", 0, nw, 0);
        @(posedge clk);
        #1 fifo_empty = 1'b0;
        @(posedge clk);
        #1 fifo_empty = 1'b1;
        @(negedge clk);
        chk("lit_clr_next_acc_en",   0, a_ae[0], 1);
        chk("lit_clr_next_zero_sel", 0, a_zs[0], 1);

        // Asynchronous reset mid-word, with byte_idx=2 and acc_en high.
        @(posedge clk);
        #1 fifo_empty = 1'b0;
        @(posedge clk);
        #1 fifo_empty = 1'b1;
        chk("lit_pre_rst_idx", 0, a_idx[0], 2);
        chk("lit_pre_rst_ae",  0, a_ae[0], 1);
        reset_n = 1'b0;
        #1;
        chk("lit_mid_rst_acc_en",   0, a_ae[0], 0);
        chk("lit_mid_rst_zero_sel", 0, a_zs[0], 0);
        chk("lit_mid_rst_write",    0, a_wr[0], 0);
        chk("lit_mid_rst_byte_idx", 0, a_idx[0], 0);
        chk("lit_mid_rst_ram_addr", 0, a_addr[0], 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        fifo_empty = 1'b0;
        repeat (4) @(posedge clk);
        #1 fifo_empty = 1'b1;
        nw = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (a_wr[0]) begin
                nw++;
                chk("lit_post_rst_addr", 0, a_addr[0], 0);
            end
        end
        chk("lit_post_rst_nwrites", 0, nw, 1);

        // Randomised traffic, checked by the model every cycle.
        for (int k = 0; k < 3000; k++) begin
            @(posedge clk);
            #1;
            if (!reset_n) begin
                reset_n = 1'b1;
            end else if ($urandom_range(0, 499) == 0) begin
                reset_n = 1'b0;
            end
            fifo_empty = ($urandom_range(0, 9) < 3);
            enable     = ($urandom_range(0, 9) != 0);
            clear      = ($urandom_range(0, 59) == 0);
        end
        @(posedge clk);
        #1 reset_n = 1'b1;
        clear = 1'b0;
        fifo_empty = 1'b1;
        repeat (4) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
